// File: rtl/color_blob_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : color_blob_tracker_if
//  Description : Pixel-mask stream in, per-frame blob statistics out.
//  Revision    : 1.0  initial release
// ============================================================================
interface color_blob_tracker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int XW         = 10,
    parameter int YW         = 9
);
    localparam int c_cw = XW + YW;

    logic                  pix_valid;
    logic                  pix_sof;
    logic                  pix_eol;
    logic [DATA_WIDTH-1:0] mask;

    logic                  busy;
    logic                  res_valid;
    logic                  res_found;
    logic [c_cw-1:0]       res_count;
    logic [XW-1:0]         res_xmin;
    logic [XW-1:0]         res_xmax;
    logic [YW-1:0]         res_ymin;
    logic [YW-1:0]         res_ymax;
    logic [XW-1:0]         res_cx;
    logic [YW-1:0]         res_cy;
    logic                  frame_err;

    modport master (
        output pix_valid, pix_sof, pix_eol, mask,
        input  busy, res_valid, res_found, res_count,
        input  res_xmin, res_xmax, res_ymin, res_ymax, res_cx, res_cy, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_eol, mask,
        output busy, res_valid, res_found, res_count,
        output res_xmin, res_xmax, res_ymin, res_ymax, res_cx, res_cy, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/color_blob_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : color_blob_tracker
//  Description : Per-frame object count, bounding box and centroid of a mask.
//  Revision    : 1.0  initial release
// ============================================================================
module color_blob_tracker #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int THRESH     = 127,
    parameter int MIN_PIXELS = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    color_blob_tracker_if.slave     bus
);
    localparam int c_cw      = XW + YW;
    localparam int c_sxw     = c_cw + XW;
    localparam int c_syw     = c_cw + YW;
    localparam int c_div_cyc = (XW > YW) ? XW : YW;
    localparam int c_aw      = c_cw + c_div_cyc;
    localparam int c_dcw     = $clog2(c_div_cyc + 1);

    localparam logic [XW:0]           c_img_w    = (XW+1)'(IMG_W);
    localparam logic [XW:0]           c_x_one    = (XW+1)'(1);
    localparam logic [YW-1:0]         c_y_one    = YW'(1);
    localparam logic [XW-1:0]         c_xmin_rst = XW'(IMG_W - 1);
    localparam logic [YW-1:0]         c_last_y   = YW'(IMG_H - 1);
    localparam logic [c_cw-1:0]       c_min_pix  = c_cw'(MIN_PIXELS);
    localparam logic [DATA_WIDTH-1:0] c_thresh   = DATA_WIDTH'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DIVIDE = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t              r_state;
    logic [XW:0]         r_x;
    logic [YW-1:0]       r_y;
    logic [c_cw-1:0]     r_cnt;
    logic [c_sxw-1:0]    r_sum_x;
    logic [c_syw-1:0]    r_sum_y;
    logic [XW-1:0]       r_xmin, r_xmax;
    logic [YW-1:0]       r_ymin, r_ymax;
    logic [c_aw-1:0]     r_rem_x, r_rem_y, r_div;
    logic [XW-1:0]       r_qx;
    logic [YW-1:0]       r_qy;
    logic [c_dcw-1:0]    r_dcnt;

    logic                r_busy, r_res_valid, r_res_found;
    logic [c_cw-1:0]     r_res_count;
    logic [XW-1:0]       r_res_xmin, r_res_xmax, r_res_cx;
    logic [YW-1:0]       r_res_ymin, r_res_ymax, r_res_cy;

    // A sof pixel is processed as x=0,y=0 against freshly cleared accumulators.
    logic                w_accept, w_restart, w_obj, w_last, w_found;
    logic [XW:0]         w_px, w_x_n;
    logic [XW-1:0]       w_px_s;
    logic [YW-1:0]       w_py, w_y_n;
    logic [c_cw-1:0]     w_cnt_b, w_cnt_n;
    logic [c_sxw-1:0]    w_sum_x_b, w_sum_x_n;
    logic [c_syw-1:0]    w_sum_y_b, w_sum_y_n;
    logic [XW-1:0]       w_xmin_b, w_xmax_b, w_xmin_n, w_xmax_n;
    logic [YW-1:0]       w_ymin_b, w_ymax_b, w_ymin_n, w_ymax_n;
    logic                w_bx, w_by;
    logic [XW-1:0]       w_qx_n;
    logic [YW-1:0]       w_qy_n;

    assign w_accept  = bus.pix_valid &&
                       ((r_state == S_IDLE && bus.pix_sof) || r_state == S_ACTIVE);
    assign w_restart = bus.pix_sof;
    assign w_px      = w_restart ? '0 : r_x;
    assign w_py      = w_restart ? '0 : r_y;
    assign w_px_s    = w_px[XW-1:0];
    assign w_obj     = (bus.mask > c_thresh) && (w_px < c_img_w);

    assign w_cnt_b   = w_restart ? '0         : r_cnt;
    assign w_sum_x_b = w_restart ? '0         : r_sum_x;
    assign w_sum_y_b = w_restart ? '0         : r_sum_y;
    assign w_xmin_b  = w_restart ? c_xmin_rst : r_xmin;
    assign w_xmax_b  = w_restart ? '0         : r_xmax;
    assign w_ymin_b  = w_restart ? c_last_y   : r_ymin;
    assign w_ymax_b  = w_restart ? '0         : r_ymax;

    assign w_cnt_n   = w_cnt_b + {{(c_cw-1){1'b0}}, w_obj};
    assign w_sum_x_n = w_sum_x_b + (w_obj ? c_sxw'(w_px) : '0);
    assign w_sum_y_n = w_sum_y_b + (w_obj ? c_syw'(w_py) : '0);
    assign w_xmin_n  = (w_obj && w_px_s < w_xmin_b) ? w_px_s : w_xmin_b;
    assign w_xmax_n  = (w_obj && w_px_s > w_xmax_b) ? w_px_s : w_xmax_b;
    assign w_ymin_n  = (w_obj && w_py   < w_ymin_b) ? w_py   : w_ymin_b;
    assign w_ymax_n  = (w_obj && w_py   > w_ymax_b) ? w_py   : w_ymax_b;

    assign w_x_n     = bus.pix_eol ? '0 : ((w_px == c_img_w) ? w_px : w_px + c_x_one);
    assign w_y_n     = bus.pix_eol ? w_py + c_y_one : w_py;
    assign w_last    = bus.pix_eol && (w_py == c_last_y);
    assign w_found   = (w_cnt_n >= c_min_pix);

    // Restoring division: r_div walks down from count<<(DIV_CYC-1) to count.
    assign w_bx      = (r_rem_x >= r_div);
    assign w_by      = (r_rem_y >= r_div);
    assign w_qx_n    = (r_qx << 1) | {{(XW-1){1'b0}}, w_bx};
    assign w_qy_n    = (r_qy << 1) | {{(YW-1){1'b0}}, w_by};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_sum_x     <= '0;
            r_sum_y     <= '0;
            r_xmin      <= c_xmin_rst;
            r_xmax      <= '0;
            r_ymin      <= c_last_y;
            r_ymax      <= '0;
            r_rem_x     <= '0;
            r_rem_y     <= '0;
            r_div       <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_dcnt      <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_found <= 1'b0;
            r_res_count <= '0;
            r_res_xmin  <= '0;
            r_res_xmax  <= '0;
            r_res_ymin  <= '0;
            r_res_ymax  <= '0;
            r_res_cx    <= '0;
            r_res_cy    <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_ACTIVE: begin
                    if (w_accept) begin
                        r_x     <= w_x_n;
                        r_y     <= w_y_n;
                        r_cnt   <= w_cnt_n;
                        r_sum_x <= w_sum_x_n;
                        r_sum_y <= w_sum_y_n;
                        r_xmin  <= w_xmin_n;
                        r_xmax  <= w_xmax_n;
                        r_ymin  <= w_ymin_n;
                        r_ymax  <= w_ymax_n;
                        if (!w_last) begin
                            r_state <= S_ACTIVE;
                        end else if (w_found) begin
                            r_state <= S_DIVIDE;
                            r_busy  <= 1'b1;
                            r_rem_x <= c_aw'(w_sum_x_n);
                            r_rem_y <= c_aw'(w_sum_y_n);
                            r_div   <= c_aw'(w_cnt_n) << (c_div_cyc - 1);
                            r_qx    <= '0;
                            r_qy    <= '0;
                            r_dcnt  <= c_dcw'(c_div_cyc - 1);
                        end else begin
                            // Too few pixels: report count only, geometry zeroed.
                            r_state     <= S_REPORT;
                            r_busy      <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_res_found <= 1'b0;
                            r_res_count <= w_cnt_n;
                            r_res_xmin  <= '0;
                            r_res_xmax  <= '0;
                            r_res_ymin  <= '0;
                            r_res_ymax  <= '0;
                            r_res_cx    <= '0;
                            r_res_cy    <= '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (w_bx) r_rem_x <= r_rem_x - r_div;
                    if (w_by) r_rem_y <= r_rem_y - r_div;
                    r_div <= r_div >> 1;
                    r_qx  <= w_qx_n;
                    r_qy  <= w_qy_n;
                    if (r_dcnt == '0) begin
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
                        r_res_found <= 1'b1;
                        r_res_count <= r_cnt;
                        r_res_xmin  <= r_xmin;
                        r_res_xmax  <= r_xmax;
                        r_res_ymin  <= r_ymin;
                        r_res_ymax  <= r_ymax;
                        r_res_cx    <= w_qx_n;
                        r_res_cy    <= w_qy_n;
                    end else begin
                        r_dcnt <= r_dcnt - c_dcw'(1);
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_found = r_res_found;
    assign bus.res_count = r_res_count;
    assign bus.res_xmin  = r_res_xmin;
    assign bus.res_xmax  = r_res_xmax;
    assign bus.res_ymin  = r_res_ymin;
    assign bus.res_ymax  = r_res_ymax;
    assign bus.res_cx    = r_res_cx;
    assign bus.res_cy    = r_res_cy;
    // Flags a sof arriving inside an unfinished frame, in the same cycle.
    assign bus.frame_err = !rst && (r_state == S_ACTIVE) && bus.pix_valid && bus.pix_sof;

endmodule
`default_nettype wire
